operand_fetch: RTL
==================

// Module: operand_fetch
// PURPOSE
//  Read-side companion of the GPR file. Accepts decoded instructions and reads rs/rt from the
//  register file's combinational read ports. Merges in same-cycle writeback data, including the
//  LCL/LCH partial merges. Tracks in-flight destinations in a scoreboard and stalls on RAW/WAW
//  hazards. Sits between decode and execute; emits one operand pair per accepted instruction
//  through a valid/ready pipeline register.
// PARAMETERS
//  GPR_W     32  operand/data width (= `GPR_WIDTH)
//  NREGS     16  architected registers (= `REGISTER_FILE_SIZE)
//  IDX_W      5  register index width; indices >= NREGS read as 0 and are never busy
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      reset, asynchronous, active-high
//  in_valid     in   1      decode presents an instruction
//  in_ready     out  1      instruction accepted when in_valid & in_ready
//  in_rs/in_rt  in   IDX_W  source indices
//  in_rd        in   IDX_W  destination index
//  in_wr        in   1      instruction will write in_rd
//  rf_rs/rf_rt  out  IDX_W  index to register file read ports (= in_rs/in_rt, combinational)
//  rf_data_rs   in   GPR_W  register file read data for rf_rs
//  rf_data_rt   in   GPR_W  register file read data for rf_rt
//  wb_en        in   1      writeback this cycle (same signal driving the file's en)
//  wb_ctrl      in   CTRL_W write mode: CTRL_LCL, CTRL_LCH, otherwise full write
//  wb_rd        in   IDX_W  writeback destination
//  wb_data      in   GPR_W  writeback data (unshifted, as sent to the file)
//  flush        in   1      kill the held output entry
//  out_valid    out  1      operands valid
//  out_ready    in   1      execute consumes when out_valid & out_ready
//  out_a/out_b  out  GPR_W  rs/rt operand values
//  out_rd       out  IDX_W  destination, passed through
//  out_wr       out  1      write flag, passed through
// BEHAVIOUR
//  Reset: out_valid=0; out_a=out_b=0; out_rd=0; out_wr=0; busy[NREGS-1:0]=0.
//  Bypass (combinational, per source s): if wb_en & wb_rd==s then
//   LCL: val = wb_data | (rf & 32'hFFFF0000); LCH: val = (wb_data<<16) | (rf & 32'h0000FFFF);
//   full: val = wb_data; else val = rf. Index >= NREGS gives val = 0.
//  eff_busy[i] = busy[i] & ~(wb_en & wb_rd==i).
//  hazard = eff_busy[rs] | eff_busy[rt] | (in_wr & eff_busy[rd]).
//  in_ready = ~hazard & (~out_valid | out_ready) & ~flush.
//  Accept: the output register loads val_rs, val_rt, in_rd, in_wr at the next edge;
//   out_valid=1. Latency is one cycle from accept to out_valid.
//  Hold: out_valid & ~out_ready keeps all outputs stable. Without a new accept,
//   out_ready clears out_valid.
//  Scoreboard per edge: clear busy[wb_rd] on wb_en; set busy[in_rd] on accept & in_wr.
//   If set and clear hit the same index, set wins (the new producer owns it).
//  A second writeback to a clear register is a no-op, with no error.
//  flush: out_valid->0 next edge; busy[out_rd] cleared if out_valid & out_wr. No accept that
//   cycle. Flush has priority over out_ready.
//  rst mid-operation: all state returns to reset values immediately, so in-flight entries are lost.
// STRUCTURE
//  lapido_defs.v: GPR_WIDTH, REGISTER_FILE_SIZE, CTRL_WIDTH, CTRL_LCL, CTRL_LCH (shared
//   with the register file; merge masks 32'hFFFF0000/32'h0000FFFF defined there too).
//  Sub-module reg_scoreboard: busy vector, set/clear ports, eff_busy lookup for 3 indices.
//  Bypass merge is a local function used twice; the output register is in the top.
// TESTING
//  1 Issue rs=1,rt=2 (r1=5,r2=7), out_ready=1 -> next cycle out_valid=1, out_a=5, out_b=7.
//  2 Issue rd=3 wr, then rs=3: stalls (in_ready=0) until wb_en,wb_rd=3,data=9 -> out_a=9 via bypass.
//  3 r4=32'h12345678; wb LCH rd=4 data=16'hABCD same cycle as read rs=4 -> out_a=32'hABCD5678.
//  4 out_ready=0 for 3 cycles with out_valid=1 -> outputs stable, in_ready=0; release -> next accepted.
//  5 Issue rd=5 wr and wb rd=5 in the same cycle -> busy[5] stays 1; a later rs=5 stalls.
//  6 flush with out_valid=1, out_rd=6, out_wr=1 -> out_valid=0, busy[6]=0; rst mid-stall -> all zero.

Source files
------------

// File: rtl/operand_fetch_pkg.sv
// Shared definitions for the operand fetch stage and the GPR file it reads.
//   GPR_WIDTH / REGISTER_FILE_SIZE / IDX_WIDTH : default datapath geometry
//   CTRL_WIDTH, CTRL_*                        : writeback mode encoding
//   MASK_HI / MASK_LO                         : halves kept by the LCL / LCH partial writes
package operand_fetch_pkg;

  localparam int GPR_WIDTH          = 32;
  localparam int REGISTER_FILE_SIZE = 16;
  localparam int IDX_WIDTH          = 5;
  localparam int CTRL_WIDTH         = 2;

  // Any encoding other than LCL/LCH is a full-word write.
  localparam logic [CTRL_WIDTH-1:0] CTRL_FULL = 2'd0;
  localparam logic [CTRL_WIDTH-1:0] CTRL_LCL  = 2'd1;
  localparam logic [CTRL_WIDTH-1:0] CTRL_LCH  = 2'd2;

  // LCL replaces the low half and keeps MASK_HI; LCH replaces the high half and keeps MASK_LO.
  localparam logic [31:0] MASK_HI = 32'hFFFF_0000;
  localparam logic [31:0] MASK_LO = 32'h0000_FFFF;

endpackage

// File: rtl/operand_fetch_reg_scoreboard.sv
// reg_scoreboard: one busy bit per architected register, marking registers with an
// in-flight producer.
//   clk, rst                 clock, asynchronous active-high reset
//   wb_clr_en / wb_clr_idx   writeback clear; also hides the bit in this cycle's lookups
//   fl_clr_en / fl_clr_idx   clear for a flushed output entry
//   set_en / set_idx         new producer accepted; wins over a clear of the same index
//   rs_idx/rt_idx/rd_idx     lookup indices
//   rs_busy/rt_busy/rd_busy  effective busy for each lookup (0 for indices >= NREGS)
module reg_scoreboard #(
  parameter int NREGS = 16,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_clr_en,
  input  logic [IDX_W-1:0] wb_clr_idx,
  input  logic             fl_clr_en,
  input  logic [IDX_W-1:0] fl_clr_idx,
  input  logic             set_en,
  input  logic [IDX_W-1:0] set_idx,
  input  logic [IDX_W-1:0] rs_idx,
  input  logic [IDX_W-1:0] rt_idx,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rs_busy,
  output logic             rt_busy,
  output logic             rd_busy
);

  localparam int SEL_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;

  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return int'(idx) < NREGS;
  endfunction

  // A register being written back this cycle is no longer a hazard.
  function automatic logic eff_busy(input logic [NREGS-1:0] bv,
                                    input logic             clr_en,
                                    input logic [IDX_W-1:0] clr_idx,
                                    input logic [IDX_W-1:0] idx);
    if (!in_range(idx)) return 1'b0;
    return bv[idx[SEL_W-1:0]] & ~(clr_en & (clr_idx == idx));
  endfunction

  always_comb begin
    rs_busy = eff_busy(busy, wb_clr_en, wb_clr_idx, rs_idx);
    rt_busy = eff_busy(busy, wb_clr_en, wb_clr_idx, rt_idx);
    rd_busy = eff_busy(busy, wb_clr_en, wb_clr_idx, rd_idx);
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    busy_nxt = busy;
    // A clear of an already-clear bit is harmless, so repeated writebacks need no checking.
    if (wb_clr_en && in_range(wb_clr_idx)) busy_nxt[wb_clr_idx[SEL_W-1:0]] = 1'b0;
    if (fl_clr_en && in_range(fl_clr_idx)) busy_nxt[fl_clr_idx[SEL_W-1:0]] = 1'b0;
    // Set comes last so it overrides a same-index clear: the new producer owns the register.
    if (set_en && in_range(set_idx))       busy_nxt[set_idx[SEL_W-1:0]]    = 1'b1;
  end

  // NOTE: state is updated with non-blocking assignments; blocking ones race with readers on the same edge.
  // NOTE: the busy vector is small control state, so it is reset to give a clean scoreboard after rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: read side of the GPR file between decode and execute.
// Reads rs/rt through the file's combinational ports, merges same-cycle writeback data
// (full, LCL, LCH), stalls on RAW/WAW hazards via reg_scoreboard, and presents one
// operand pair per accepted instruction through a valid/ready output register.
//   clk, rst                    clock, asynchronous active-high reset
//   in_valid/in_ready           decode handshake; in_rs, in_rt, in_rd, in_wr instruction fields
//   rf_rs/rf_rt, rf_data_*      register file read ports
//   wb_en/wb_ctrl/wb_rd/wb_data writeback bus as driven into the file
//   flush                       kill the held output entry
//   out_valid/out_ready         execute handshake; out_a, out_b, out_rd, out_wr payload
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int GPR_W = GPR_WIDTH,
  parameter int NREGS = REGISTER_FILE_SIZE,
  parameter int IDX_W = IDX_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IDX_W-1:0]      in_rs,
  input  logic [IDX_W-1:0]      in_rt,
  input  logic [IDX_W-1:0]      in_rd,
  input  logic                  in_wr,
  output logic [IDX_W-1:0]      rf_rs,
  output logic [IDX_W-1:0]      rf_rt,
  input  logic [GPR_W-1:0]      rf_data_rs,
  input  logic [GPR_W-1:0]      rf_data_rt,
  input  logic                  wb_en,
  input  logic [CTRL_WIDTH-1:0] wb_ctrl,
  input  logic [IDX_W-1:0]      wb_rd,
  input  logic [GPR_W-1:0]      wb_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [GPR_W-1:0]      out_a,
  output logic [GPR_W-1:0]      out_b,
  output logic [IDX_W-1:0]      out_rd,
  output logic                  out_wr
);

  logic             rs_busy, rt_busy, rd_busy;
  logic             hazard;
  logic             accept;
  logic [GPR_W-1:0] val_rs, val_rt;

  assign rf_rs = in_rs;
  assign rf_rt = in_rt;

  // Value a source would see once this cycle's writeback has landed in the file.
  function automatic logic [GPR_W-1:0] bypass(input logic [IDX_W-1:0]      src,
                                              input logic [GPR_W-1:0]      rf,
                                              input logic                  en,
                                              input logic [CTRL_WIDTH-1:0] ctrl,
                                              input logic [IDX_W-1:0]      rd,
                                              input logic [GPR_W-1:0]      data);
    if (int'(src) >= NREGS) return '0;
    if (!(en && (rd == src))) return rf;
    case (ctrl)
      CTRL_LCL: return data | (rf & GPR_W'(MASK_HI));
      CTRL_LCH: return (data << 16) | (rf & GPR_W'(MASK_LO));
      default:  return data;
    endcase
  endfunction

  always_comb begin
    val_rs = bypass(in_rs, rf_data_rs, wb_en, wb_ctrl, wb_rd, wb_data);
    val_rt = bypass(in_rt, rf_data_rt, wb_en, wb_ctrl, wb_rd, wb_data);
  end

  reg_scoreboard #(
    .NREGS (NREGS),
    .IDX_W (IDX_W)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .wb_clr_en  (wb_en),
    .wb_clr_idx (wb_rd),
    .fl_clr_en  (flush & out_valid & out_wr),
    .fl_clr_idx (out_rd),
    .set_en     (accept & in_wr),
    .set_idx    (in_rd),
    .rs_idx     (in_rs),
    .rt_idx     (in_rt),
    .rd_idx     (in_rd),
    .rs_busy    (rs_busy),
    .rt_busy    (rt_busy),
    .rd_busy    (rd_busy)
  );

  // RAW on either source, WAW only if this instruction writes.
  assign hazard   = rs_busy | rt_busy | (in_wr & rd_busy);
  assign in_ready = ~hazard & (~out_valid | out_ready) & ~flush;
  assign accept   = in_valid & in_ready;

  // Flush outranks everything; a plain drain only drops valid when nothing replaces it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_rd    <= '0;
      out_wr    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_a     <= val_rs;
      out_b     <= val_rt;
      out_rd    <= in_rd;
      out_wr    <= in_wr;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
